digit_line_decoder: RTL

DIGIT_LINE_DECODER -- requirements
Module: digit_line_decoder

---
 rtl/digit_line_decoder.sv | 107 ++++++++++
 1 files changed

// File: rtl/digit_line_decoder.sv
// digit_line_decoder
//   Accumulates a decimal entry, most-significant digit first, into a
//   binary value and hands the committed result to a consumer through a
//   valid/ready handshake.
//
// Ports
//   Clk         rising-edge clock
//   Reset_n     asynchronous active-low reset
//   Clear       synchronous abort of the current entry (highest priority)
//   DigitValid  DigitIn carries a digit
//   DigitIn     4-bit digit code; codes above 9 are consumed but flag an error
//   DigitReady  a digit can be accepted this cycle (state/count decode only)
//   Commit      end of entry, request the result
//   Value       committed value in DONE, live accumulator otherwise
//   ValueErr    entry contained an invalid digit code
//   DigitCount  digits accepted in the current entry
//   ValueValid  Value/ValueErr/DigitCount hold a committed result
//   ValueReady  consumer accepts the result
module digit_line_decoder #(
    parameter int NUM_DIGIT = 3,
    parameter int VALUE_W   = $clog2(10**NUM_DIGIT)
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             Clear,
    input  logic                             DigitValid,
    input  logic [3:0]                       DigitIn,
    output logic                             DigitReady,
    input  logic                             Commit,
    output logic [VALUE_W-1:0]               Value,
    output logic                             ValueErr,
    output logic [$clog2(NUM_DIGIT+1)-1:0]   DigitCount,
    output logic                             ValueValid,
    input  logic                             ValueReady
);

    localparam int CNT_W = $clog2(NUM_DIGIT+1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(NUM_DIGIT);
    localparam logic [VALUE_W-1:0] TEN     = VALUE_W'(10);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        DONE
    } state_t;

    state_t             state;
    logic [VALUE_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               err;

    logic               xfer;
    logic               digit_ok;
    logic [VALUE_W-1:0] acc_mac;

    assign DigitReady = (state == IDLE) || ((state == ENTRY) && (cnt < CNT_MAX));
    assign xfer       = DigitValid && DigitReady;
    assign digit_ok   = (DigitIn <= 4'd9);
    // Entries are capped at NUM_DIGIT digits, so this never wraps.
    assign acc_mac    = (acc * TEN) + VALUE_W'(DigitIn);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (Clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    // A digit arriving with Commit still lands in the result.
                    if (xfer) begin
                        cnt <= cnt + CNT_W'(1);
                        if (digit_ok)
                            acc <= acc_mac;
                        else
                            err <= 1'b1;
                    end
                    if (Commit)
                        state <= DONE;
                    else if (xfer)
                        state <= ENTRY;
                end
                DONE: begin
                    if (ValueReady) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Value      = acc;
    assign ValueErr   = err;
    assign DigitCount = cnt;
    assign ValueValid = (state == DONE);

endmodule
